// File: rtl/uart_cmd_core.sv
// uart_cmd_core: pin-constrained UART tile with command-byte reset request.
// Receives 8N1 frames on io_in7[0] and can echo each good byte on io_out8[0].
// io_out8[7:1] shows either the received byte or the status flags.
// A received RESET_CMD byte pulses io_resetCommandStrobe for one cycle.
// Optional build macro: UART_PARITY_EN switches both directions to 8E1 framing
// and enables the sticky parity_err flag. Without it parity_err reads 0.
module uart_cmd_core #(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] RESET_CMD    = 8'h12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] io_in7,
  output logic [7:0] io_out8,
  output logic       io_resetCommandStrobe
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  logic             echo_en_s;
  logic             out_sel_s;
  logic             unused_in_s;

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;

  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]       rx_bit_r, rx_bit_s;
  logic [7:0]       rx_shift_r, rx_shift_s;
  logic             rx_done_s;
  logic             rx_par_ok_s;
  logic             rx_good_s;

  tx_state_t        tx_state_r, tx_state_s;
  logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]       tx_bit_r, tx_bit_s;
  logic [7:0]       tx_shift_r, tx_shift_s;
  logic             tx_line_r, tx_line_s;
  logic             tx_idle_s;
  logic             tx_start_s;

  logic [7:0]       rx_data_r;
  logic             byte_toggle_r;
  logic             framing_err_r;
  logic             overrun_r;
  logic             strobe_r;
  logic             parity_err_s;
  logic             rx_busy_s;

`ifdef UART_PARITY_EN
  logic             rx_par_r, rx_par_s;
  logic             tx_par_r, tx_par_s;
  logic             parity_err_r;
`endif

  assign echo_en_s   = io_in7[1];
  assign out_sel_s   = io_in7[2];
  assign unused_in_s = &{1'b0, io_in7[6:3]};

  // Two-flop synchronizer on rx plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= io_in7[0];
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX state register; a reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
`ifdef UART_PARITY_EN
      rx_par_r   <= 1'b0;
`endif
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
`ifdef UART_PARITY_EN
      rx_par_r   <= rx_par_s;
`endif
    end
  end

  // RX next state: mid-bit sampling, LSB-first shift, stop-bit sample pulse.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_done_s  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_s   = rx_par_r;
`endif
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = '0;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = '0;
          rx_bit_s = 3'd0;
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = '0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_s = RX_PARITY;
`else
            rx_state_s = RX_STOP;
`endif
          end else begin
            rx_bit_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = '0;
          rx_par_s   = rx_sync_r;
          rx_state_s = RX_STOP;
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = '0;
          rx_done_s  = 1'b1;
          rx_state_s = RX_IDLE;
        end else begin
          rx_cnt_s = rx_cnt_r + 1'b1;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = '0;
      end
    endcase
  end

`ifdef UART_PARITY_EN
  assign rx_par_ok_s  = (rx_par_r == even_parity(rx_shift_r));
  assign parity_err_s = parity_err_r;
`else
  assign rx_par_ok_s  = 1'b1;
  assign parity_err_s = 1'b0;
`endif

  // A byte is accepted only with a good stop bit (and good parity when enabled).
  assign rx_good_s  = rx_done_s & rx_sync_r & rx_par_ok_s;
  assign tx_idle_s  = (tx_state_r == TX_IDLE);
  assign tx_start_s = rx_good_s & echo_en_s & tx_idle_s;
  assign rx_busy_s  = (rx_state_r != RX_IDLE);

  // TX state register; the line idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_r   <= 1'b0;
`endif
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      tx_line_r  <= tx_line_s;
`ifdef UART_PARITY_EN
      tx_par_r   <= tx_par_s;
`endif
    end
  end

  // TX next state and next line level; the start bit leaves on the accept edge.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
`ifdef UART_PARITY_EN
    tx_par_s   = tx_par_r;
`endif
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = '0;
        if (tx_start_s) begin
          tx_state_s = TX_START;
          tx_shift_s = rx_shift_r;
`ifdef UART_PARITY_EN
          tx_par_s   = even_parity(rx_shift_r);
`endif
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = '0;
          tx_bit_s   = 3'd0;
          tx_state_s = TX_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = '0;
          if (tx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_s = TX_PARITY;
`else
            tx_state_s = TX_STOP;
`endif
          end else begin
            tx_bit_s   = tx_bit_r + 3'd1;
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = '0;
          tx_state_s = TX_STOP;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = '0;
          tx_state_s = TX_IDLE;
        end else begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = '0;
      end
    endcase

    case (tx_state_s)
      TX_START:  tx_line_s = 1'b0;
      TX_DATA:   tx_line_s = tx_shift_s[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_line_s = tx_par_s;
`endif
      default:   tx_line_s = 1'b1;
    endcase
  end

  // Received byte, toggle, command strobe and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_r     <= 8'h00;
      byte_toggle_r <= 1'b0;
      framing_err_r <= 1'b0;
      overrun_r     <= 1'b0;
      strobe_r      <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r  <= 1'b0;
`endif
    end else begin
      strobe_r <= rx_good_s && (rx_shift_r == RESET_CMD);
      if (rx_good_s) begin
        rx_data_r     <= rx_shift_r;
        byte_toggle_r <= ~byte_toggle_r;
      end
      if (rx_done_s && !rx_sync_r) begin
        framing_err_r <= 1'b1;
      end
      if (rx_good_s && echo_en_s && !tx_idle_s) begin
        overrun_r <= 1'b1;
      end
`ifdef UART_PARITY_EN
      if (rx_done_s && rx_sync_r && !rx_par_ok_s) begin
        parity_err_r <= 1'b1;
      end
`endif
    end
  end

  // Output mux straight from registers; bit 0 is always the tx line.
  always_comb begin
    io_out8 = {7'b0000000, tx_line_r};
    case (out_sel_s)
      1'b0:    io_out8[7:1] = rx_data_r[6:0];
      1'b1:    io_out8[7:1] = {overrun_r, byte_toggle_r, ~tx_idle_s, rx_busy_s,
                               parity_err_s, framing_err_r, rx_data_r[7]};
      default: io_out8[7:1] = 7'b0000000;
    endcase
  end

  assign io_resetCommandStrobe = strobe_r;

endmodule

// File: tb/tb_uart_cmd_core.sv
// Scoreboard bench for uart_cmd_core: the stimulus side predicts received
// bytes, echo frames and status snapshots; a monitor compares DUT outputs.
module tb_uart_cmd_core;

  localparam int         CPB  = 8;
  localparam logic [7:0] RCMD = 8'h12;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_line = 1'b1;
  logic       echo_en = 1'b0;
  logic       out_sel = 1'b0;
  logic [6:0] io_in7;
  logic [7:0] io_out8;
  logic       strobe;

  assign io_in7 = {4'b0000, out_sel, echo_en, rx_line};

  uart_cmd_core #(.CLKS_PER_BIT(CPB), .RESET_CMD(RCMD)) dut (
    .clk(clk),
    .reset(reset),
    .io_in7(io_in7),
    .io_out8(io_out8),
    .io_resetCommandStrobe(strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       strobe;
  } rx_exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ovr;
    logic       tog;
  } chk_t;

  rx_exp_t    exp_rx[$];
  logic [7:0] exp_tx[$];
  chk_t       exp_chk[$];
  string      chk_name[$];

  // Reference model state
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0, m_tog = 1'b0;
  int         tx_free = 0;

  function automatic logic [NB-1:0] make_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic [NB-1:0] f;
    f = '0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9] = (^b) ^ bad_par;
`else
    if (bad_par) f[0] = 1'b0;
`endif
    f[NB-1] = ~bad_stop;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Predict the outcome of a frame, then drive it bit by bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par, input int stop_len);
    logic [NB-1:0] f;
    int tc;
    f  = make_frame(b, bad_stop, bad_par);
    tc = cyc + (NB - 1) * CPB + CPB / 2;
    if (bad_stop) begin
      m_fe = 1'b1;
    end else if (bad_par) begin
      m_pe = 1'b1;
    end else begin
      m_data = b;
      m_tog  = ~m_tog;
      exp_rx.push_back('{data: b, strobe: (b == RCMD)});
      if (echo_en) begin
        if (tc >= tx_free) begin
          exp_tx.push_back(b);
          tx_free = tc + NB * CPB;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      rx_line = f[i];
      tick((i == NB - 1) ? stop_len : CPB);
    end
    rx_line = 1'b1;
  endtask

  task automatic push_chk(input string tag);
    exp_chk.push_back('{data: m_data, fe: m_fe, pe: m_pe, ovr: m_ovr, tog: m_tog});
    chk_name.push_back(tag);
    tick(2);
  endtask

  // Let any echo finish before snapshotting the status.
  task automatic checkpoint(input string tag);
    tick(NB * CPB + 2 * CPB);
    push_chk(tag);
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    rx_line = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_rx.delete();
    exp_tx.delete();
    m_data = 8'h00; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0; m_tog = 1'b0;
    tx_free = 0;
    push_chk(tag);
  endtask

  // Monitor: reads both mux views each cycle and checks against the queues.
  initial begin
    logic [7:0]    lo, hi, rxd;
    logic          prev_tog;
    logic          prev_tx;
    int            rst_hold;
    bit            cap;
    int            tcyc;
    logic [NB-1:0] tbits;
    rx_exp_t       e;
    chk_t          c;
    string         nm;
    logic [7:0]    tb;
    prev_tog = 1'b0; prev_tx = 1'b1; rst_hold = 0; cap = 0; tcyc = 0; tbits = '0;
    forever begin
      @(negedge clk);
      out_sel = 1'b0;
      #1 lo = io_out8;
      out_sel = 1'b1;
      #1 hi = io_out8;
      rxd = {hi[1], lo[7:1]};
      if (reset) begin
        rst_hold = 2;
        cap = 0;
      end
      if (exp_chk.size() > 0) begin
        c  = exp_chk.pop_front();
        nm = chk_name.pop_front();
        check({nm, "_sel0"}, lo, {c.data[6:0], 1'b1});
        check({nm, "_sel1"}, hi, {c.ovr, c.tog, 1'b0, 1'b0, c.pe, c.fe, c.data[7], 1'b1});
        check({nm, "_strobe"}, strobe, 1'b0);
      end
      if (rst_hold > 0) begin
        rst_hold--;
      end else begin
        if (hi[6] != prev_tog) begin
          if (exp_rx.size() == 0) begin
            check("rx_unexpected_byte", rxd, 32'hFFFF_FFFF);
          end else begin
            e = exp_rx.pop_front();
            check("rx_data", rxd, e.data);
            check("rx_strobe", strobe, e.strobe);
          end
        end else if (strobe) begin
          check("strobe_spurious", strobe, 1'b0);
        end
        if (!cap) begin
          if (lo[0] == 1'b0 && prev_tx == 1'b1) begin
            cap  = 1;
            tcyc = 0;
          end
        end else begin
          tcyc++;
        end
        if (cap && (tcyc % CPB == CPB / 2)) begin
          tbits[tcyc / CPB] = lo[0];
          check("tx_busy", hi[5], 1'b1);
          if (tcyc / CPB == NB - 1) begin
            cap = 0;
            if (exp_tx.size() == 0) begin
              check("tx_unexpected_frame", tbits, 32'hFFFF_FFFF);
            end else begin
              tb = exp_tx.pop_front();
              check("tx_frame", tbits, make_frame(tb, 1'b0, 1'b0));
            end
          end
        end
      end
      prev_tog = hi[6];
      prev_tx  = lo[0];
    end
  end

  // Stimulus
  initial begin
    logic [7:0] b;
    logic [NB-1:0] pf;
    tick(3);
    reset = 1'b0;
    exp_rx.delete();
    push_chk("reset_idle");

    echo_en = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, CPB);
    checkpoint("a5_no_echo");

    echo_en = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, CPB);
    checkpoint("3c_echo");

    echo_en = 1'b0;
    send_frame(RCMD, 1'b0, 1'b0, CPB);
    checkpoint("reset_cmd");
    send_frame(8'h13, 1'b0, 1'b0, CPB);
    checkpoint("not_cmd");

    send_frame(8'h55, 1'b1, 1'b0, CPB);
    checkpoint("framing_err");
    send_frame(RCMD, 1'b1, 1'b0, CPB);
    checkpoint("cmd_bad_stop");

    do_reset("reset_clear");
    rx_line = 1'b0;
    tick(2);
    rx_line = 1'b1;
    checkpoint("glitch");

    echo_en = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0, CPB - 2);
    send_frame(8'h7E, 1'b0, 1'b0, CPB);
    checkpoint("overrun");

    do_reset("reset_after_ovr");
    send_frame(8'h5A, 1'b0, 1'b0, CPB);
    pf = make_frame(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rx_line = pf[i];
      tick(CPB);
    end
    do_reset("reset_mid_frame");
    checkpoint("after_mid_reset");

    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 5) b = RCMD;
      echo_en = 1'($urandom_range(0, 1));
      send_frame(b, 1'b0, 1'b0, CPB);
      tick(3 * CPB + $urandom_range(0, CPB));
      if (i % 4 == 3) checkpoint("random");
    end

    echo_en = 1'b1;
    send_frame(RCMD, 1'b0, 1'b0, CPB);
    checkpoint("cmd_echo");

`ifdef UART_PARITY_EN
    send_frame(RCMD, 1'b0, 1'b1, CPB);
    checkpoint("parity_err");
`endif

    tick(4 * NB * CPB);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("chk_queue_drained", exp_chk.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
